// File: rtl/counter_sequencer_if.sv
// counter_sequencer_if: switch inputs, counter feedback and counter control bus
//   s0, s1    raw direction/restart and rate switches
//   mode      operating mode (00 manual, 01 bounce, 10 sweep, 11 hold)
//   q_in      current counter value
//   cnt_en    count-enable pulse,  cnt_ud  direction (1=up)
//   cnt_load  load strobe,         load_val  load value
//   tick      prescaler tick,      state     FSM state
interface counter_sequencer_if;
    logic       s0;
    logic       s1;
    logic [1:0] mode;
    logic [7:0] q_in;
    logic       cnt_en;
    logic       cnt_ud;
    logic       cnt_load;
    logic [7:0] load_val;
    logic       tick;
    logic [1:0] state;
    modport master (
        output s0, s1, mode, q_in,
        input  cnt_en, cnt_ud, cnt_load, load_val, tick, state
    );
    modport slave (
        input  s0, s1, mode, q_in,
        output cnt_en, cnt_ud, cnt_load, load_val, tick, state
    );
endinterface

// File: rtl/counter_sequencer.sv
// counter_sequencer: rate prescaler, switch debounce and mode FSM driving an 8-bit up/down counter
//   CLK  system clock
//   RST  synchronous active-high reset
//   bus  slave side of counter_sequencer_if (switches, mode, counter feedback in; counter control out)
module counter_sequencer #(
    parameter int         DIV_SLOW  = 50000000,
    parameter int         DIV_FAST  = 12500000,
    parameter int         DB_CYCLES = 500000,
    parameter logic [7:0] LO        = 8'h00,
    parameter logic [7:0] HI        = 8'hFF
) (
    input logic               CLK,
    input logic               RST,
    counter_sequencer_if.slave bus
);
    localparam int PW = $clog2(DIV_SLOW > DIV_FAST ? DIV_SLOW : DIV_FAST);
    localparam int DW = $clog2(DB_CYCLES + 1);
    typedef enum logic [1:0] {LOAD = 2'b00, RUN = 2'b01, DONE = 2'b10, HOLD = 2'b11} state_t;
    state_t        st;
    logic          s0_m, s0_s, s0_db, s1_m, s1_s, s1_db, dir;
    logic [DW-1:0] s0_cnt, s1_cnt;
    logic [PW-1:0] pre;
    logic [1:0]    mode_r, mode_p;
    logic [7:0]    qc;
    logic          s0_hit, s1_hit, s0_rise, pre_end, tick_n, mode_chg, dir_n;
    always_comb begin
        s0_hit   = s0_s != s0_db && s0_cnt == DW'(DB_CYCLES - 1);
        s1_hit   = s1_s != s1_db && s1_cnt == DW'(DB_CYCLES - 1);
        s0_rise  = s0_hit && s0_s;
        pre_end  = pre == (s1_db ? PW'(DIV_FAST - 1) : PW'(DIV_SLOW - 1));
        // a rate change restarts the prescaler and swallows the tick
        tick_n   = pre_end && !s1_hit;
        mode_chg = mode_r != mode_p;
        // out-of-range counter values are treated as the nearest limit
        qc       = bus.q_in >= HI ? HI : bus.q_in <= LO ? LO : bus.q_in;
        dir_n    = qc >= HI ? 1'b0 : qc <= LO ? 1'b1 : dir;
    end
    assign bus.state = st;
    always_ff @(posedge CLK) begin
        if (RST) begin
            {s0_m, s0_s, s0_db, s1_m, s1_s, s1_db} <= '0;
            s0_cnt       <= '0;
            s1_cnt       <= '0;
            pre          <= '0;
            mode_r       <= 2'b00;
            mode_p       <= 2'b00;
            dir          <= 1'b1;
            st           <= LOAD;
            bus.cnt_en   <= 1'b0;
            bus.cnt_ud   <= 1'b1;
            bus.cnt_load <= 1'b0;
            bus.load_val <= LO;
            bus.tick     <= 1'b0;
        end else begin
            s0_m         <= bus.s0;
            s0_s         <= s0_m;
            s1_m         <= bus.s1;
            s1_s         <= s1_m;
            s0_cnt       <= (s0_s == s0_db || s0_hit) ? '0 : s0_cnt + 1'b1;
            s1_cnt       <= (s1_s == s1_db || s1_hit) ? '0 : s1_cnt + 1'b1;
            if (s0_hit) s0_db <= s0_s;
            if (s1_hit) s1_db <= s1_s;
            pre          <= (s1_hit || pre_end) ? '0 : pre + 1'b1;
            bus.tick     <= tick_n;
            mode_r       <= bus.mode;
            mode_p       <= mode_r;
            bus.cnt_en   <= 1'b0;
            bus.cnt_load <= 1'b0;
            if (mode_chg) st <= LOAD;
            else case (st)
                LOAD: begin
                    bus.cnt_load <= 1'b1;
                    bus.load_val <= LO;
                    bus.cnt_ud   <= 1'b1;
                    dir          <= 1'b1;
                    st           <= mode_r == 2'b11 ? HOLD : RUN;
                end
                // the tick right behind a load would see a stale Q_IN, so it is skipped
                RUN: if (tick_n && !bus.cnt_load) case (mode_r)
                    2'b00: begin
                        bus.cnt_ud <= s0_db;
                        bus.cnt_en <= s0_db ? qc < HI : qc > LO;
                    end
                    2'b01: begin
                        dir        <= dir_n;
                        bus.cnt_ud <= dir_n;
                        bus.cnt_en <= 1'b1;
                    end
                    2'b10: begin
                        bus.cnt_ud <= 1'b1;
                        bus.cnt_en <= qc < HI;
                        if (qc >= HI) st <= DONE;
                    end
                    default: ;
                endcase
                DONE: if (s0_rise) st <= LOAD;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_counter_sequencer.sv
// tb_counter_sequencer: scoreboard bench for counter_sequencer with a load-priority counter model
module tb_counter_sequencer;
    typedef struct {
        logic [7:0] q;
        logic       en;
        logic       ud;
    } exp_t;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] q = 8'd0;
    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;
    int         n_load = 0;
    int         t0, l0;
    exp_t       sb[$];
    exp_t       e;
    byte unsigned bq[10] = '{3, 4, 5, 6, 5, 4, 3, 4, 5, 6};
    bit           bu[10] = '{1, 1, 1, 0, 0, 0, 1, 1, 1, 0};
    counter_sequencer_if bus();
    counter_sequencer #(
        .DIV_SLOW(8), .DIV_FAST(4), .DB_CYCLES(4), .LO(8'd3), .HI(8'd6)
    ) dut (
        .CLK(clk), .RST(rst), .bus(bus)
    );
    always #5 clk = ~clk;
    assign bus.q_in = q;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.cnt_load) q <= bus.load_val;
        else if (bus.cnt_en) q <= bus.cnt_ud ? q + 8'd1 : q - 8'd1;
    end
    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    always @(negedge clk) begin
        if (bus.cnt_load) n_load++;
        if (!rst && bus.tick && sb.size() > 0) begin
            e = sb.pop_front();
            chk("tick_q_in", bus.q_in, e.q);
            chk("tick_cnt_en", bus.cnt_en, e.en);
            chk("tick_cnt_ud", bus.cnt_ud, e.ud);
        end
    end
    task automatic push(logic [7:0] qv, logic en, logic ud, int n = 1);
        repeat (n) sb.push_back('{qv, en, ud});
    endtask
    task automatic wait_tick();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.tick && n < 64);
        chk("tick_seen", bus.tick, 1);
    endtask
    task automatic sync();
        wait_tick();
        @(negedge clk);
    endtask
    task automatic drain();
        int n = 0;
        while (sb.size() > 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("drain", sb.size(), 0);
    endtask
    task automatic check_reset();
        chk("rst_cnt_en", bus.cnt_en, 0);
        chk("rst_cnt_ud", bus.cnt_ud, 1);
        chk("rst_cnt_load", bus.cnt_load, 0);
        chk("rst_load_val", bus.load_val, 3);
        chk("rst_tick", bus.tick, 0);
        chk("rst_state", bus.state, 0);
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
    initial begin
        bus.s0   = 1'b0;
        bus.s1   = 1'b0;
        bus.mode = 2'b01;
        repeat (3) @(negedge clk);
        check_reset();
        rst = 1'b0;
        @(negedge clk);
        chk("first_load", bus.cnt_load, 1);
        chk("first_state", bus.state, 1);
        foreach (bq[i]) push(bq[i], 1'b1, bu[i]);
        drain();
        @(negedge clk);
        chk("q_before_rst", q, 5);
        rst = 1'b1;
        @(negedge clk);
        check_reset();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_reload", bus.cnt_load, 1);
        chk("rst_state_run", bus.state, 1);
        for (int i = 3; i <= 5; i++) push(i[7:0], 1'b1, 1'b1);
        drain();
        sync();
        l0 = n_load;
        bus.mode = 2'b11;
        push(8'd3, 1'b0, 1'b1, 10);
        drain();
        chk("hold_state", bus.state, 3);
        chk("hold_loads", n_load - l0, 1);
        sync();
        bus.mode = 2'b01;
        for (int i = 3; i <= 5; i++) push(i[7:0], 1'b1, 1'b1);
        drain();
        sync();
        bus.mode = 2'b00;
        bus.s0   = 1'b1;
        for (int i = 3; i <= 5; i++) push(i[7:0], 1'b1, 1'b1);
        push(8'd6, 1'b0, 1'b1, 3);
        drain();
        chk("manual_state", bus.state, 1);
        sync();
        bus.s0 = 1'b0;
        for (int i = 6; i >= 4; i--) push(i[7:0], 1'b1, 1'b0);
        push(8'd3, 1'b0, 1'b0, 2);
        drain();
        sync();
        bus.mode = 2'b10;
        for (int i = 3; i <= 5; i++) push(i[7:0], 1'b1, 1'b1);
        push(8'd6, 1'b0, 1'b1, 2);
        drain();
        chk("sweep_done", bus.state, 2);
        sync();
        bus.s0 = 1'b1;
        push(8'd6, 1'b0, 1'b1);
        for (int i = 3; i <= 5; i++) push(i[7:0], 1'b1, 1'b1);
        push(8'd6, 1'b0, 1'b1);
        drain();
        chk("sweep_done_again", bus.state, 2);
        sync();
        repeat (3) begin
            bus.s1 = 1'b1;
            repeat (2) @(negedge clk);
            bus.s1 = 1'b0;
            repeat (2) @(negedge clk);
        end
        wait_tick();
        t0 = cyc;
        wait_tick();
        chk("gap_after_glitch", cyc - t0, 8);
        wait_tick();
        t0 = cyc;
        @(negedge clk);
        bus.s1 = 1'b1;
        wait_tick();
        chk("gap_rate_change", cyc - t0, 11);
        t0 = cyc;
        wait_tick();
        chk("gap_fast", cyc - t0, 4);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
